// File: rtl/memory_access.sv
// rtl/memory_access.sv - pipeline stage 4: data-memory access over req/ack bus with MEM/WB register
module memory_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [1:0]  WB_in,
    input  logic [2:0]  MEM_in,
    input  logic [4:0]  RD_in,
    input  logic [31:0] ALU_in,
    input  logic [31:0] WriteData_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        valid_out,
    output logic [1:0]  WB_out,
    output logic [4:0]  RD_out,
    output logic [31:0] ALU_out,
    output logic [31:0] ReadData_out,
    output logic        err_out
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // Counter value seen in the last WAIT cycle allowed before aborting.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [0:0]  r_state;
    logic [7:0]  r_cnt;

    logic        r_dmem_req;
    logic        r_dmem_we;
    logic [31:0] r_dmem_addr;
    logic [31:0] r_dmem_wdata;

    // Bundle captured at accept so completion does not depend on upstream holding.
    logic [1:0]  r_wb_hold;
    logic [4:0]  r_rd_hold;

    logic        r_valid_out;
    logic [1:0]  r_wb_out;
    logic [4:0]  r_rd_out;
    logic [31:0] r_alu_out;
    logic [31:0] r_rdata_out;
    logic        r_err;

    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_memop;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_bad;
    logic        w_idle;
    logic        w_wait;
    logic        w_start;
    logic        w_pass;
    logic        w_ack;
    logic        w_tmo;
    logic        w_branch_unused;

    // Branch is resolved elsewhere; this stage only carries the bit in.
    assign w_branch_unused = MEM_in[2];

    assign w_mem_read   = MEM_in[1];
    assign w_mem_write  = MEM_in[0];
    assign w_memop      = w_mem_read | w_mem_write;
    assign w_illegal    = w_mem_read & w_mem_write;
    assign w_misaligned = w_memop & (ALU_in[1:0] != 2'b00);
    assign w_bad        = w_illegal | w_misaligned;

    assign w_idle  = (r_state == S_IDLE);
    assign w_wait  = (r_state == S_WAIT);

    // Legal aligned access: goes to the bus. Everything else valid is a one-cycle pass.
    assign w_start = w_idle & valid_in & w_memop & ~w_bad;
    assign w_pass  = w_idle & valid_in & ~w_start;

    // Ack takes priority over timeout in the same cycle.
    assign w_ack   = w_wait & dmem_ack;
    assign w_tmo   = w_wait & ~dmem_ack & (r_cnt == TMO_LAST);

    assign stall_out = w_start | (w_wait & ~dmem_ack & ~w_tmo);

    // State machine and timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            if (w_start) begin
                r_state <= S_WAIT;
                r_cnt   <= 8'd0;
            end else if (w_ack || w_tmo) begin
                r_state <= S_IDLE;
                r_cnt   <= 8'd0;
            end else if (w_wait) begin
                r_cnt   <= r_cnt + 8'd1;
            end
        end
    end

    // Bus request and held transfer attributes, stable for the whole WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= 32'd0;
            r_dmem_wdata <= 32'd0;
            r_wb_hold    <= 2'b00;
            r_rd_hold    <= 5'd0;
        end else begin
            if (w_start) begin
                r_dmem_req   <= 1'b1;
                r_dmem_we    <= w_mem_write;
                r_dmem_addr  <= ALU_in;
                r_dmem_wdata <= WriteData_in;
                r_wb_hold    <= WB_in;
                r_rd_hold    <= RD_in;
            end else if (w_ack || w_tmo) begin
                r_dmem_req   <= 1'b0;
            end
        end
    end

    // MEM/WB register: pass-through, completed access, or aborted access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_out <= 1'b0;
            r_wb_out    <= 2'b00;
            r_rd_out    <= 5'd0;
            r_alu_out   <= 32'd0;
            r_rdata_out <= 32'd0;
        end else begin
            r_valid_out <= 1'b0;
            if (w_pass) begin
                r_valid_out <= 1'b1;
                r_wb_out    <= w_bad ? 2'b00 : WB_in;
                r_rd_out    <= RD_in;
                r_alu_out   <= ALU_in;
                r_rdata_out <= 32'd0;
            end else if (w_ack) begin
                r_valid_out <= 1'b1;
                r_wb_out    <= r_wb_hold;
                r_rd_out    <= r_rd_hold;
                r_alu_out   <= r_dmem_addr;
                r_rdata_out <= r_dmem_we ? 32'd0 : dmem_rdata;
            end else if (w_tmo) begin
                r_valid_out <= 1'b1;
                r_wb_out    <= 2'b00;
                r_rd_out    <= r_rd_hold;
                r_alu_out   <= r_dmem_addr;
                r_rdata_out <= 32'd0;
            end
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((w_pass && w_bad) || w_tmo) begin
            r_err <= 1'b1;
        end
    end

    assign dmem_req     = r_dmem_req;
    assign dmem_we      = r_dmem_we;
    assign dmem_addr    = r_dmem_addr;
    assign dmem_wdata   = r_dmem_wdata;
    assign valid_out    = r_valid_out;
    assign WB_out       = r_wb_out;
    assign RD_out       = r_rd_out;
    assign ALU_out      = r_alu_out;
    assign ReadData_out = r_rdata_out;
    assign err_out      = r_err;

endmodule
